// File: rtl/fp_mul_normround.sv
// fp_mul_normround: FP32 multiply normalise (S1) / RNE round+pack (S2) pipeline, FTZ/DAZ; FPU_STICKY_FLAGS_EN adds a sticky flag accumulator
module fp_mul_normround #(
  parameter int PROD_W = 64,
  parameter int EXP_W  = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic signed [EXP_W-1:0] in_exp,
  input  logic [PROD_W-1:0]       in_prod,
  input  logic [2:0]              in_class,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_result,
  output logic [3:0]              out_flags
`ifdef FPU_STICKY_FLAGS_EN
  ,
  input  logic                    flags_clr,
  output logic [3:0]              sticky_flags
`endif
);
  logic                    s1_valid, s1_sign, s1_guard, s1_sticky;
  logic signed [EXP_W:0]   s1_exp;
  logic [22:0]             s1_mant;
  logic [2:0]              s1_class;
  logic                    hi, s2_free, rnd, nx;
  logic [22:0]             n_mant;
  logic                    n_guard, n_sticky;
  logic signed [EXP_W:0]   n_exp, e_r;
  logic [23:0]             m24;
  logic [31:0]             n_result;
  logic [3:0]              n_flags;
  logic                    unused_prod;
  assign unused_prod = ^in_prod[PROD_W-1:48];
  assign s2_free  = !out_valid | out_ready;
  assign in_ready = !s1_valid | s2_free;
  // Normalise: pick the 23 fraction bits below the leading one and collapse the rest into guard/sticky.
  always_comb begin
    hi       = in_prod[47];
    n_mant   = hi ? in_prod[46:24] : in_prod[45:23];
    n_guard  = hi ? in_prod[23] : in_prod[22];
    n_sticky = hi ? |in_prod[22:0] : |in_prod[21:0];
    n_exp    = {in_exp[EXP_W-1], in_exp} + {{EXP_W{1'b0}}, hi};
  end
  // Round to nearest even and pack; special classes override the arithmetic result.
  always_comb begin
    rnd      = s1_guard & (s1_sticky | s1_mant[0]);
    nx       = s1_guard | s1_sticky;
    m24      = {1'b0, s1_mant} + {23'h0, rnd};
    e_r      = s1_exp + {{EXP_W{1'b0}}, m24[23]};
    n_result = s1_class == 3'd1 ? {s1_sign, 31'h0} :
               s1_class == 3'd2 ? {s1_sign, 8'hFF, 23'h0} :
               s1_class != 3'd0 ? 32'h7FC00000 :
               s1_exp <= 0      ? {s1_sign, 31'h0} :
               e_r >= 255       ? {s1_sign, 8'hFF, 23'h0} :
                                  {s1_sign, e_r[7:0], m24[22:0]};
    n_flags  = s1_class == 3'd1 || s1_class == 3'd2 || s1_class == 3'd3 ? 4'b0000 :
               s1_class != 3'd0 ? 4'b1000 :
               s1_exp <= 0      ? 4'b0011 :
               e_r >= 255       ? 4'b0101 :
                                  {3'b000, nx};
  end
  // S1 loads whenever it is empty or its beat moves into S2 this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_exp    <= '0;
      s1_mant   <= '0;
      s1_guard  <= 1'b0;
      s1_sticky <= 1'b0;
      s1_class  <= '0;
    end else if (in_ready) begin
      s1_valid  <= in_valid;
      s1_sign   <= in_sign;
      s1_exp    <= n_exp;
      s1_mant   <= n_mant;
      s1_guard  <= n_guard;
      s1_sticky <= n_sticky;
      s1_class  <= in_class;
    end
  end
  // Output register holds its beat steady until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else if (s2_free) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= n_result;
        out_flags  <= n_flags;
      end
    end
  end
`ifdef FPU_STICKY_FLAGS_EN
  // Accumulate flags of every delivered beat; a clear coinciding with a transfer keeps only that beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_flags <= '0;
    else if (flags_clr) sticky_flags <= (out_valid & out_ready) ? out_flags : 4'h0;
    else if (out_valid & out_ready) sticky_flags <= sticky_flags | out_flags;
  end
`endif
endmodule

// File: tb/tb_fp_mul_normround.sv
// tb_fp_mul_normround: directed checks of normalise/round, specials, handshake, backpressure and reset
module tb_fp_mul_normround;
  logic              clk = 0, rst_n = 0, in_valid = 0, in_sign = 0, out_ready = 1;
  logic              in_ready, out_valid;
  logic signed [9:0] in_exp = 0;
  logic [63:0]       in_prod = 0;
  logic [2:0]        in_class = 0;
  logic [31:0]       out_result;
  logic [3:0]        out_flags;
  int                n_cmp = 0, n_bad = 0;
`ifdef FPU_STICKY_FLAGS_EN
  logic              flags_clr = 0;
  logic [3:0]        sticky_flags;
`endif

  always #5 clk = ~clk;

  fp_mul_normround dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_prod(in_prod), .in_class(in_class),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags)
`ifdef FPU_STICKY_FLAGS_EN
    , .flags_clr(flags_clr), .sticky_flags(sticky_flags)
`endif
  );

  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_result !== 32'h0) begin n_bad++; $display("FAIL reset_out_result: got %h want 00000000", out_result); end
    n_cmp++; if (out_flags !== 4'h0) begin n_bad++; $display("FAIL reset_out_flags: got %b want 0000", out_flags); end
    rst_n = 1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  // One beat at a time: result, flags and the 2-cycle latency.
  task automatic test_directed;
    logic        sg [17] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1};
    logic signed [9:0] ex [17] = '{127, 127, 127, 254, 0, 127, 127, 254, 254, 0, -10'sd5, 127, 127, 5, 127, 127, 127};
    logic [47:0] pr [17] = '{48'h900000000000, 48'h400000400000, 48'h400000C00000, 48'h800000000000,
                             48'h400000000000, 48'h123456789ABC, 48'h7FFFFFC00000, 48'h7FFFFFC00000,
                             48'h400000000000, 48'h800000000000, 48'hC00000000000, 48'h900000000000,
                             48'h900000000000, 48'h900000000000, 48'h900000000000, 48'h400000000001,
                             48'h800001800000};
    logic [2:0]  cl [17] = '{0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0, 1, 2, 3, 7, 0, 0};
    logic [31:0] er [17] = '{32'h40100000, 32'h3F800000, 32'h3F800002, 32'h7F800000, 32'h80000000,
                             32'h7FC00000, 32'h40000000, 32'h7F800000, 32'h7F000000, 32'h00800000,
                             32'h80000000, 32'h80000000, 32'hFF800000, 32'h7FC00000, 32'h7FC00000,
                             32'h3F800000, 32'hC0000002};
    logic [3:0]  ef [17] = '{4'b0000, 4'b0001, 4'b0001, 4'b0101, 4'b0011, 4'b1000, 4'b0001, 4'b0101,
                             4'b0000, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0001,
                             4'b0001};
    for (int i = 0; i < 17; i++) begin
      int lat;
      @(negedge clk);
      out_ready = 1;
      in_sign   = sg[i];
      in_exp    = ex[i];
      in_prod   = {16'hDEAD, pr[i]};
      in_class  = cl[i];
      in_valid  = 1;
      @(posedge clk);
      #1 in_valid = 0;
      lat = 0;
      for (int c = 1; c <= 8 && lat == 0; c++) begin
        @(negedge clk);
        if (out_valid) lat = c;
      end
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL vec%0d_latency: got %0d want 2", i, lat); end
      n_cmp++; if (out_result !== er[i]) begin n_bad++; $display("FAIL vec%0d_result: got %h want %h", i, out_result, er[i]); end
      n_cmp++; if (out_flags !== ef[i]) begin n_bad++; $display("FAIL vec%0d_flags: got %b want %b", i, out_flags, ef[i]); end
    end
  endtask

  // Four consecutive beats with out_ready=1: one result per cycle, in order.
  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready%0d: got %b want 1", i, in_ready); end
      if (i >= 2 && i < 6) begin
        n_cmp++; if (out_valid !== 1'b1 || out_result !== 32'h3F800004 + 32'(i - 2)) begin
          n_bad++; $display("FAIL b2b_out%0d: got v=%b %h want v=1 %h", i, out_valid, out_result, 32'h3F800004 + 32'(i - 2));
        end
      end else begin
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_idle%0d: got %b want 0", i, out_valid); end
      end
      in_valid = i < 4;
      in_sign = 0; in_exp = 127; in_class = 0;
      in_prod = {16'h0, 48'h400000000000 | (48'(i + 4) << 23)};
    end
    in_valid = 0;
  endtask

  task automatic drive_beat(input int k);
    in_valid = 1; in_sign = 0; in_exp = 127; in_class = 0;
    in_prod = {16'h0, 48'h400000000000 | (48'(k) << 23)};
  endtask

  // Two beats fill the pipe with the consumer stalled; a third must wait.
  task automatic test_backpressure;
    @(negedge clk);
    out_ready = 0;
    drive_beat(1);
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_one: got %b want 1", in_ready); end
    drive_beat(2);
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_full: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b1 || out_result !== 32'h3F800001) begin n_bad++; $display("FAIL bp_hold_a: got v=%b %h want v=1 3f800001", out_valid, out_result); end
    drive_beat(3);
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_still: got %b want 0", in_ready); end
    @(negedge clk);
    n_cmp++; if (out_result !== 32'h3F800001 || out_flags !== 4'h0) begin n_bad++; $display("FAIL bp_stable: got %h/%b want 3f800001/0000", out_result, out_flags); end
    out_ready = 1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_release: got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 0;
    n_cmp++; if (out_valid !== 1'b1 || out_result !== 32'h3F800002) begin n_bad++; $display("FAIL bp_out_b: got v=%b %h want v=1 3f800002", out_valid, out_result); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || out_result !== 32'h3F800003) begin n_bad++; $display("FAIL bp_out_c: got v=%b %h want v=1 3f800003", out_valid, out_result); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drained: got %b want 0", out_valid); end
  endtask

  // Reset with two beats in flight: immediate clear, nothing stale afterwards.
  task automatic test_reset_midflight;
    int seen, lat;
    @(negedge clk);
    out_ready = 0;
    drive_beat(7);
    @(negedge clk);
    drive_beat(8);
    @(negedge clk);
    in_valid = 0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rst_pre_valid: got %b want 1", out_valid); end
    rst_n = 0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_result !== 32'h0) begin n_bad++; $display("FAIL rst_async_clear: got v=%b %h want v=0 00000000", out_valid, out_result); end
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rst_no_stale: got %0d beats want 0", seen); end
    drive_beat(9);
    @(posedge clk);
    #1 in_valid = 0;
    lat = 0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      if (out_valid) lat = c;
    end
    n_cmp++; if (lat !== 2 || out_result !== 32'h3F800009) begin n_bad++; $display("FAIL rst_after_beat: got lat=%0d %h want lat=2 3f800009", lat, out_result); end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_backpressure;
    test_reset_midflight;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
